// File: rtl/mgt_01_alu_reservation_station_pkg.sv
// Shared types for the ALU reservation station: operation codes, data words,
// ROB tags, FU handshake state and the per-entry storage record.
// No logic lives here except the CDB capture helper used by dispatch and snoop.
package mgt_01_alu_reservation_station_pkg;

  localparam int RS_DEPTH_DEFAULT = 4;
  localparam int TAG_W_DEFAULT    = 4;
  localparam int DATA_W           = 32;

  // Storage width of every tag held inside an entry.
  typedef logic [TAG_W_DEFAULT-1:0] rob_tag_t;

  typedef enum logic {
    BUSY  = 1'b0,
    READY = 1'b1
  } fu_state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_ops_e;

  typedef logic [DATA_W-1:0] data_bus_t;

  // Same bits viewed raw (as carried on the CDB) or as a signed operand.
  typedef union packed {
    data_bus_t                 raw;
    logic signed [DATA_W-1:0]  s;
  } data_u;

  typedef struct packed {
    data_u    value;
    logic     ready;
    rob_tag_t tag;
  } operand_t;

  typedef struct packed {
    logic     valid;
    alu_ops_e ops;
    rob_tag_t rob_tag;
    operand_t a;
    operand_t b;
  } rs_entry_t;

  // A waiting operand picks up the broadcast value when its producer tag
  // matches; an operand that is already ready is left untouched.
  function automatic operand_t capture_operand(input operand_t  cur,
                                               input logic      cdb_vld,
                                               input rob_tag_t  cdb_tag,
                                               input data_bus_t cdb_dat);
    operand_t res;
    res = cur;
    if (!cur.ready && cdb_vld && (cur.tag == cdb_tag)) begin
      res.value.raw = cdb_dat;
      res.ready     = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mgt_01_alu_reservation_station_picker.sv
// Lowest-index-first priority picker: one-hot grant of the lowest set request bit.
// Latency: purely combinational. Backpressure: none, the caller qualifies the grant.
// Ports: i_req request vector, o_gnt one-hot grant (zero when idle), o_vld any request.
module mgt_01_priority_picker
  import mgt_01_alu_reservation_station_pkg::*;
#(
  parameter int N = RS_DEPTH_DEFAULT
) (
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt,
  output logic         o_vld
);

  // Two's complement isolates the lowest set bit: req & -req.
  assign o_gnt = i_req & (~i_req + N'(1));
  assign o_vld = |i_req;

endmodule

// File: rtl/mgt_01_alu_reservation_station.sv
// ALU reservation station: holds dispatched ops until both operands are ready
// (captured from dispatch or CDB), then issues the lowest-index eligible entry.
// Latency: 2 edges dispatch-to-issue minimum. Backpressure: full_o stalls dispatch,
// fu_state_i=BUSY holds issue; flush_i drops everything at the next edge.
// Ports: clk_i/rst_n_i, dispatch_* (new op + operands), cdb_* (result broadcast),
// flush_i, fu_state_i (ALU can accept), full_o, issue_* / op_*_o / ops_o (to ALU).
module mgt_01_alu_reservation_station
  import mgt_01_alu_reservation_station_pkg::*;
#(
  parameter int RS_DEPTH = RS_DEPTH_DEFAULT,
  parameter int TAG_W    = TAG_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             dispatch_valid_i,
  input  alu_ops_e         dispatch_ops_i,
  input  logic [TAG_W-1:0] dispatch_rob_tag_i,
  input  data_u            dispatch_A_i,
  input  data_u            dispatch_B_i,
  input  logic             dispatch_A_rdy_i,
  input  logic             dispatch_B_rdy_i,
  input  logic [TAG_W-1:0] dispatch_A_tag_i,
  input  logic [TAG_W-1:0] dispatch_B_tag_i,
  input  logic             cdb_valid_i,
  input  logic [TAG_W-1:0] cdb_tag_i,
  input  data_bus_t        cdb_data_i,
  input  logic             flush_i,
  input  logic             fu_state_i,
  output logic             full_o,
  output logic             issue_valid_o,
  output data_u            op_A_o,
  output data_u            op_B_o,
  output alu_ops_e         ops_o,
  output logic [TAG_W-1:0] issue_rob_tag_o
);

  rs_entry_t           r_entries     [RS_DEPTH];
  rs_entry_t           w_entries_nxt [RS_DEPTH];
  rs_entry_t           w_new_entry;

  logic [RS_DEPTH-1:0] w_free_req;
  logic [RS_DEPTH-1:0] w_elig_req;
  logic [RS_DEPTH-1:0] w_free_gnt;
  logic [RS_DEPTH-1:0] w_issue_gnt;
  logic                w_free_any;
  logic                w_elig_any;
  logic                w_fu_ready;
  logic                w_do_dispatch;
  logic                w_do_issue;
  rob_tag_t            w_cdb_tag;

  // Fields of the entry chosen for issue.
  alu_ops_e            w_sel_ops;
  rob_tag_t            w_sel_tag;
  data_u               w_sel_a;
  data_u               w_sel_b;

  // Issue register.
  logic                r_issue_valid;
  alu_ops_e            r_ops;
  rob_tag_t            r_issue_tag;
  data_u               r_op_a;
  data_u               r_op_b;

  assign w_cdb_tag  = rob_tag_t'(cdb_tag_i);
  assign w_fu_ready = (fu_state_e'(fu_state_i) == READY);

  // Request vectors come from registered state only, so a CDB capture or a
  // dispatch in this cycle cannot make an entry eligible before the next one.
  always_comb begin
    w_free_req = '0;
    w_elig_req = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_free_req[i] = ~r_entries[i].valid;
      w_elig_req[i] = r_entries[i].valid & r_entries[i].a.ready & r_entries[i].b.ready;
    end
  end

  mgt_01_priority_picker #(.N(RS_DEPTH)) u_free_picker (
    .i_req (w_free_req),
    .o_gnt (w_free_gnt),
    .o_vld (w_free_any)
  );

  mgt_01_priority_picker #(.N(RS_DEPTH)) u_issue_picker (
    .i_req (w_elig_req),
    .o_gnt (w_issue_gnt),
    .o_vld (w_elig_any)
  );

  // A slot freed by this cycle's issue is not visible here: full_o looks at
  // pre-edge state, so that slot becomes usable one cycle later.
  assign full_o        = ~w_free_any;
  assign w_do_dispatch = dispatch_valid_i & w_free_any;
  assign w_do_issue    = w_fu_ready & w_elig_any;

  // Incoming entry, with same-cycle CDB forwarding into a waiting operand.
  always_comb begin
    w_new_entry             = '0;
    w_new_entry.valid       = 1'b1;
    w_new_entry.ops         = dispatch_ops_i;
    w_new_entry.rob_tag     = rob_tag_t'(dispatch_rob_tag_i);
    w_new_entry.a.value     = dispatch_A_i;
    w_new_entry.a.ready     = dispatch_A_rdy_i;
    w_new_entry.a.tag       = rob_tag_t'(dispatch_A_tag_i);
    w_new_entry.b.value     = dispatch_B_i;
    w_new_entry.b.ready     = dispatch_B_rdy_i;
    w_new_entry.b.tag       = rob_tag_t'(dispatch_B_tag_i);
    w_new_entry.a = capture_operand(w_new_entry.a, cdb_valid_i, w_cdb_tag, cdb_data_i);
    w_new_entry.b = capture_operand(w_new_entry.b, cdb_valid_i, w_cdb_tag, cdb_data_i);
  end

  // One-hot grant, so at most one branch fires.
  always_comb begin
    w_sel_ops = ALU_ADD;
    w_sel_tag = '0;
    w_sel_a   = '0;
    w_sel_b   = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (w_issue_gnt[i]) begin
        w_sel_ops = r_entries[i].ops;
        w_sel_tag = r_entries[i].rob_tag;
        w_sel_a   = r_entries[i].a.value;
        w_sel_b   = r_entries[i].b.value;
      end
    end
  end

  // Per-entry next state: snoop, then free on issue, then fill on dispatch.
  // The free-slot grant only ever points at an invalid entry, so the dispatch
  // write can never collide with the entry being issued.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_entries_nxt[i] = r_entries[i];
      if (r_entries[i].valid) begin
        w_entries_nxt[i].a = capture_operand(r_entries[i].a, cdb_valid_i, w_cdb_tag, cdb_data_i);
        w_entries_nxt[i].b = capture_operand(r_entries[i].b, cdb_valid_i, w_cdb_tag, cdb_data_i);
      end
      if (w_do_issue && w_issue_gnt[i]) begin
        w_entries_nxt[i].valid = 1'b0;
      end
      if (w_do_dispatch && w_free_gnt[i]) begin
        w_entries_nxt[i] = w_new_entry;
      end
    end
  end

  // Flush only needs to drop valid bits; stale payload is never observed.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        r_entries[i] <= '0;
      end
    end else if (flush_i) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        r_entries[i].valid <= 1'b0;
      end
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        r_entries[i] <= w_entries_nxt[i];
      end
    end
  end

  // Payload registers only load on a real issue and otherwise hold their
  // last values, so the ALU side sees stable operands between pulses.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_issue_valid <= 1'b0;
      r_ops         <= ALU_ADD;
      r_issue_tag   <= '0;
      r_op_a        <= '0;
      r_op_b        <= '0;
    end else begin
      r_issue_valid <= w_do_issue & ~flush_i;
      if (w_do_issue && !flush_i) begin
        r_ops       <= w_sel_ops;
        r_issue_tag <= w_sel_tag;
        r_op_a      <= w_sel_a;
        r_op_b      <= w_sel_b;
      end
    end
  end

  assign issue_valid_o   = r_issue_valid;
  assign ops_o           = r_ops;
  assign issue_rob_tag_o = TAG_W'(r_issue_tag);
  assign op_A_o          = r_op_a;
  assign op_B_o          = r_op_b;

endmodule

// File: tb/tb_mgt_01_alu_reservation_station.sv
module tb_mgt_01_alu_reservation_station;
  import mgt_01_alu_reservation_station_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b1;
  logic       dispatch_valid_i;
  alu_ops_e   dispatch_ops_i;
  logic [3:0] dispatch_rob_tag_i;
  data_u      dispatch_A_i, dispatch_B_i;
  logic       dispatch_A_rdy_i, dispatch_B_rdy_i;
  logic [3:0] dispatch_A_tag_i, dispatch_B_tag_i;
  logic       cdb_valid_i;
  logic [3:0] cdb_tag_i;
  data_bus_t  cdb_data_i;
  logic       flush_i;
  logic       fu_state_i;
  logic       full_o;
  logic       issue_valid_o;
  data_u      op_A_o, op_B_o;
  alu_ops_e   ops_o;
  logic [3:0] issue_rob_tag_o;

  mgt_01_alu_reservation_station dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .dispatch_valid_i(dispatch_valid_i), .dispatch_ops_i(dispatch_ops_i),
    .dispatch_rob_tag_i(dispatch_rob_tag_i),
    .dispatch_A_i(dispatch_A_i), .dispatch_B_i(dispatch_B_i),
    .dispatch_A_rdy_i(dispatch_A_rdy_i), .dispatch_B_rdy_i(dispatch_B_rdy_i),
    .dispatch_A_tag_i(dispatch_A_tag_i), .dispatch_B_tag_i(dispatch_B_tag_i),
    .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i),
    .flush_i(flush_i), .fu_state_i(fu_state_i),
    .full_o(full_o), .issue_valid_o(issue_valid_o),
    .op_A_o(op_A_o), .op_B_o(op_B_o), .ops_o(ops_o),
    .issue_rob_tag_o(issue_rob_tag_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit v;
    int ops;
    int tag;
    int a; bit ar; int at;
    int b; bit br; int bt;
  } ment_t;

  ment_t me [4];
  bit    m_iv = 0;
  int    m_a = 0, m_b = 0, m_ops = 0, m_tag = 0;

  function automatic bit m_full();
    bit f = 1;
    for (int i = 0; i < 4; i++) if (!me[i].v) f = 0;
    return f;
  endfunction

  always @(posedge clk_i or negedge rst_n_i) begin : model
    int fidx, iidx;
    if (!rst_n_i) begin
      for (int i = 0; i < 4; i++) me[i].v = 0;
      m_iv = 0; m_a = 0; m_b = 0; m_ops = int'(ALU_ADD); m_tag = 0;
    end else if (flush_i) begin
      for (int i = 0; i < 4; i++) me[i].v = 0;
      m_iv = 0;
    end else begin
      fidx = -1;
      iidx = -1;
      for (int i = 0; i < 4; i++) begin
        if (!me[i].v && fidx < 0) fidx = i;
        if (me[i].v && me[i].ar && me[i].br && iidx < 0) iidx = i;
      end
      m_iv = 0;
      if (fu_state_i && iidx >= 0) begin
        m_iv = 1;
        m_a = me[iidx].a; m_b = me[iidx].b;
        m_ops = me[iidx].ops; m_tag = me[iidx].tag;
        me[iidx].v = 0;
      end
      if (cdb_valid_i) begin
        for (int i = 0; i < 4; i++) begin
          if (me[i].v && !me[i].ar && me[i].at == int'(cdb_tag_i)) begin
            me[i].ar = 1; me[i].a = int'(cdb_data_i);
          end
          if (me[i].v && !me[i].br && me[i].bt == int'(cdb_tag_i)) begin
            me[i].br = 1; me[i].b = int'(cdb_data_i);
          end
        end
      end
      if (dispatch_valid_i && fidx >= 0) begin
        me[fidx].v   = 1;
        me[fidx].ops = int'(dispatch_ops_i);
        me[fidx].tag = int'(dispatch_rob_tag_i);
        me[fidx].a   = int'(dispatch_A_i.s);
        me[fidx].ar  = dispatch_A_rdy_i;
        me[fidx].at  = int'(dispatch_A_tag_i);
        me[fidx].b   = int'(dispatch_B_i.s);
        me[fidx].br  = dispatch_B_rdy_i;
        me[fidx].bt  = int'(dispatch_B_tag_i);
        if (!me[fidx].ar && cdb_valid_i && me[fidx].at == int'(cdb_tag_i)) begin
          me[fidx].ar = 1; me[fidx].a = int'(cdb_data_i);
        end
        if (!me[fidx].br && cdb_valid_i && me[fidx].bt == int'(cdb_tag_i)) begin
          me[fidx].br = 1; me[fidx].b = int'(cdb_data_i);
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk_i) begin
    if (cmp_en) begin
      chk("model_full_o", int'(full_o), int'(m_full()));
      chk("model_issue_valid_o", int'(issue_valid_o), int'(m_iv));
      chk("model_op_A_o", int'(op_A_o.s), m_a);
      chk("model_op_B_o", int'(op_B_o.s), m_b);
      chk("model_ops_o", int'(ops_o), m_ops);
      chk("model_issue_rob_tag_o", int'(issue_rob_tag_o), m_tag);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic idle();
    dispatch_valid_i = 0;
    cdb_valid_i      = 0;
    flush_i          = 0;
  endtask

  task automatic disp(input alu_ops_e op, input int tag,
                      input int a, input bit ar, input int at,
                      input int b, input bit br, input int bt);
    dispatch_valid_i   = 1;
    dispatch_ops_i     = op;
    dispatch_rob_tag_i = 4'(tag);
    dispatch_A_i.s     = a;
    dispatch_A_rdy_i   = ar;
    dispatch_A_tag_i   = 4'(at);
    dispatch_B_i.s     = b;
    dispatch_B_rdy_i   = br;
    dispatch_B_tag_i   = 4'(bt);
  endtask

  initial begin
    idle();
    disp(ALU_ADD, 0, 0, 0, 0, 0, 0, 0);
    dispatch_valid_i = 0;
    cdb_tag_i  = 0;
    cdb_data_i = '0;
    fu_state_i = 1;

    #2 rst_n_i = 0;
    cmp_en = 1;
    tick(); tick();
    chk("reset_full", int'(full_o), 0);
    chk("reset_issue_valid", int'(issue_valid_o), 0);
    chk("reset_op_A", int'(op_A_o.s), 0);
    chk("reset_ops", int'(ops_o), int'(ALU_ADD));
    rst_n_i = 1;

    // Both operands ready: issue two edges after dispatch.
    disp(ALU_ADD, 1, 100, 1, 0, 200, 1, 0);
    tick(); idle();
    chk("add_not_yet", int'(issue_valid_o), 0);
    tick();
    chk("add_issue_valid", int'(issue_valid_o), 1);
    chk("add_op_A", int'(op_A_o.s), 100);
    chk("add_op_B", int'(op_B_o.s), 200);
    chk("add_ops", int'(ops_o), int'(ALU_ADD));
    chk("add_tag", int'(issue_rob_tag_o), 1);
    tick();
    chk("add_single_pulse", int'(issue_valid_o), 0);

    // B waits on tag 3, broadcast arrives three cycles later.
    disp(ALU_SUB, 2, 500, 1, 0, 0, 0, 3);
    tick(); idle();
    tick(); tick();
    cdb_valid_i = 1; cdb_tag_i = 4'd3; cdb_data_i = data_bus_t'(-200);
    tick(); idle();
    chk("sub_wait_after_cdb", int'(issue_valid_o), 0);
    tick();
    chk("sub_issue_valid", int'(issue_valid_o), 1);
    chk("sub_op_A", int'(op_A_o.s), 500);
    chk("sub_op_B", int'(op_B_o.s), -200);
    chk("sub_ops", int'(ops_o), int'(ALU_SUB));
    chk("sub_tag", int'(issue_rob_tag_o), 2);
    chk("sub_result", int'(op_A_o.s) - int'(op_B_o.s), 700);
    tick();

    // Same-cycle forwarding at dispatch.
    disp(ALU_OR, 3, 1, 1, 0, 0, 0, 5);
    cdb_valid_i = 1; cdb_tag_i = 4'd5; cdb_data_i = data_bus_t'(7);
    tick(); idle();
    tick();
    chk("fwd_issue_valid", int'(issue_valid_o), 1);
    chk("fwd_op_B", int'(op_B_o.s), 7);
    chk("fwd_tag", int'(issue_rob_tag_o), 3);
    tick();

    // Fill with the ALU busy, drop a fifth, then drain in index order.
    fu_state_i = 0;
    for (int k = 0; k < 4; k++) begin
      disp(ALU_XOR, 4 + k, 10 + k, 1, 0, 20 + k, 1, 0);
      tick();
    end
    chk("fill_full", int'(full_o), 1);
    disp(ALU_XOR, 8, 99, 1, 0, 99, 1, 0);
    tick(); idle();
    fu_state_i = 1;
    chk("fill_full_after_drop", int'(full_o), 1);
    chk("fill_no_issue_busy", int'(issue_valid_o), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("drain_issue_valid", int'(issue_valid_o), 1);
      chk("drain_tag", int'(issue_rob_tag_o), 4 + k);
      chk("drain_op_A", int'(op_A_o.s), 10 + k);
      chk("drain_full", int'(full_o), 0);
    end
    tick();
    chk("drain_fifth_dropped", int'(issue_valid_o), 0);

    // Flush with a simultaneous dispatch and a ready ALU.
    fu_state_i = 0;
    for (int k = 0; k < 3; k++) begin
      disp(ALU_ADD, 9 + k, 1, 1, 0, 1, 1, 0);
      tick();
    end
    disp(ALU_ADD, 12, 2, 1, 0, 2, 1, 0);
    flush_i = 1; fu_state_i = 1;
    tick(); idle();
    chk("flush_issue_valid", int'(issue_valid_o), 0);
    chk("flush_full", int'(full_o), 0);
    tick();
    chk("flush_no_late_issue", int'(issue_valid_o), 0);
    tick();

    // Asynchronous reset with two pending entries.
    fu_state_i = 0;
    for (int k = 0; k < 2; k++) begin
      disp(ALU_SUB, 13 + k, 30, 1, 0, 5, 1, 0);
      tick();
    end
    idle();
    #2 rst_n_i = 0;
    #1;
    chk("arst_full", int'(full_o), 0);
    chk("arst_issue_valid", int'(issue_valid_o), 0);
    chk("arst_op_A", int'(op_A_o.s), 0);
    chk("arst_op_B", int'(op_B_o.s), 0);
    chk("arst_ops", int'(ops_o), int'(ALU_ADD));
    chk("arst_tag", int'(issue_rob_tag_o), 0);
    fu_state_i = 1;
    tick(); tick();
    rst_n_i = 1;
    tick();
    chk("post_rst_no_stale_1", int'(issue_valid_o), 0);
    tick();
    chk("post_rst_no_stale_2", int'(issue_valid_o), 0);
    disp(ALU_SLT, 15, 3, 1, 0, 4, 1, 0);
    tick(); idle();
    tick();
    chk("post_rst_issue_valid", int'(issue_valid_o), 1);
    chk("post_rst_tag", int'(issue_rob_tag_o), 15);
    chk("post_rst_ops", int'(ops_o), int'(ALU_SLT));
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mgt_01_alu_reservation_station.md
MGT_01_ALU_RESERVATION_STATION -- requirements
Module: MGT_01_alu_reservation_station

Interface
REQ-001 Parameter RS_DEPTH, default 4: number of entries.
REQ-002 Parameter TAG_W, default 4: ROB tag width.
REQ-003 Ports (clock and reset first):
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset.
- dispatch_valid_i  in  1  new instruction offered.
- dispatch_ops_i  in  alu_ops_e  ALU operation.
- dispatch_rob_tag_i  in  TAG_W  destination tag.
- dispatch_A_i, dispatch_B_i  in  data_u  operand values.
- dispatch_A_rdy_i, dispatch_B_rdy_i  in  1  operand value is valid.
- dispatch_A_tag_i, dispatch_B_tag_i  in  TAG_W  producer tag when not ready.
- cdb_valid_i  in  1  result broadcast.
- cdb_tag_i  in  TAG_W  broadcast tag.
- cdb_data_i  in  data_bus_t  broadcast value.
- flush_i  in  1  pipeline flush.
- fu_state_i  in  1  ALU can accept (1 = READY).
- full_o  out  1  no free entry.
- issue_valid_o  out  1  issue outputs valid.
- op_A_o, op_B_o  out  data_u  operands to ALU.
- ops_o  out  alu_ops_e  operation to ALU.
- issue_rob_tag_o  out  TAG_W  tag of issued instruction.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low (clk_i, rst_n_i).

Function
REQ-005 Each entry SHALL hold: valid, ops, rob_tag, and per operand value, ready and tag.
REQ-006 full_o SHALL be combinational from registered state: 1 iff all RS_DEPTH entries are valid.
REQ-007 When dispatch_valid_i=1 and full_o=0, the lowest-index free entry SHALL be written at the clock edge. A dispatch while full_o=1 SHALL be ignored without corrupting state.
REQ-008 Dispatch forwarding: if an operand is not ready and cdb_valid_i=1 with cdb_tag_i equal to that operand tag in the same cycle, the entry SHALL be stored with cdb_data_i and ready=1.
REQ-009 Snoop: in every valid entry, each non-ready operand whose tag equals cdb_tag_i while cdb_valid_i=1 SHALL capture cdb_data_i and set ready at the next edge. Ready operands SHALL ignore the CDB.
REQ-010 An entry is eligible when it is valid and both operands are ready. Readiness acquired at edge N makes the entry eligible in cycle N+1.
REQ-011 Issue: when fu_state_i=1 and at least one entry is eligible, the block SHALL select the lowest-index eligible entry.
  - op_A_o, op_B_o, ops_o and issue_rob_tag_o SHALL register the selected entry's contents.
  - issue_valid_o SHALL be 1 for exactly one cycle.
  - The entry SHALL be freed at the same edge.
REQ-012 If fu_state_i=0 or no entry is eligible, issue_valid_o SHALL be 0 next cycle and op_A_o, op_B_o, ops_o and issue_rob_tag_o SHALL hold their previous values.
REQ-013 Minimum latency SHALL be 2 edges: a dispatch with both operands ready at edge N gives issue_valid_o=1 after edge N+1.
REQ-014 Simultaneous dispatch and issue in one cycle SHALL both take effect. Because full_o is evaluated on pre-edge state, a slot freed by issue is usable from the next cycle only.
REQ-015 flush_i=1 SHALL clear every valid bit and issue_valid_o at the next edge. Flush SHALL have priority over dispatch, snoop and issue.

Reset
REQ-016 While rst_n_i=0, the block SHALL hold all entries invalid, full_o=0, issue_valid_o=0, op_A_o=0, op_B_o=0, ops_o=ALU_ADD and issue_rob_tag_o=0.
REQ-017 Asserting reset mid-operation SHALL discard all pending entries immediately (asynchronously). The first dispatch is accepted at the first edge after deassertion.

Structure
REQ-018 rob_tag_t, fu_state_e (READY/BUSY), the RS_DEPTH default and the rs_entry_t struct SHALL live in the shared package, alongside data_u, data_bus_t and alu_ops_e.
REQ-019 The priority selection SHALL be one sub-module, MGT_01_priority_picker: an RS_DEPTH-bit request input giving a one-hot grant and a valid flag. It SHALL be reused for both free-slot and eligible-entry selection.

Verification
REQ-020 Dispatch ADD with A=100 ready and B=200 ready, fu_state_i=1 -> issue_valid_o=1 two edges later with op_A_o=100, op_B_o=200, ops_o=ALU_ADD and the matching tag.
REQ-021 Dispatch SUB with A=500 ready and B not ready (tag 3); three cycles later cdb tag 3 with data -200 -> issue follows 2 edges after the broadcast with op_B_o=-200 (ALU result 700 expected).
REQ-022 Dispatch with B tag 5 while cdb_valid_i=1, cdb_tag_i=5, data 7 in the same cycle -> entry issues with op_B_o=7 and no further broadcast required.
REQ-023 With fu_state_i=0, fill 4 entries -> full_o=1 and a 5th dispatch is dropped. Raise fu_state_i -> entries issue in index order over 4 consecutive cycles and full_o falls after the first issue.
REQ-024 Fill 3 entries, then assert flush_i together with a dispatch -> all entries invalid, no issue_valid_o pulse, and full_o=0.
REQ-025 Assert rst_n_i=0 with 2 pending entries -> outputs go to reset values immediately and no stale issue occurs after release.
